disp_scheduler: RTL
===================

# disp_scheduler

Sequencing controller in front of the 4-digit seven-segment scan driver. It accepts distance results from the ultrasonic measurement path and error reports from the echo-timeout logic, and arbitrates between them with error priority. Accepted distances are converted binary-to-BCD over multiple cycles. It drives the four 4-bit digit inputs of the scan driver and enforces a minimum hold time per displayed value so readings stay legible.

## Interface
- DATA_W, 14: width of binary distance input, in cm; 14 bits covers 0..16383.
- HOLD_CYC, 25_000_000: minimum clocks a new value stays displayed before the next request is accepted (0.5 s at 50 MHz); must be ≥ 1.
- sys_clk50m  in  1  system clock, 50 MHz; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- meas_valid  in  1  distance request valid.
- meas_data  in  DATA_W  distance in cm, unsigned binary.
- meas_ready  out  1  distance accepted on a cycle where meas_valid && meas_ready.
- err_valid  in  1  error request valid (echo timeout).
- err_ready  out  1  error accepted on a cycle where err_valid && err_ready.
- digit0..digit3  out  4 each  BCD digits to the scan driver; digit0 = ones, digit3 = thousands.
- upd  out  1  one-cycle pulse on the cycle the digits change.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, CONV, HOLD.
- IDLE:
  - err_ready = 1.
  - meas_ready = !err_valid, a combinational decode of state and err_valid; error wins a simultaneous request.
- Error accept:
  - Next cycle, all digits = BLANK (4'hF) and upd = 1.
  - Go to HOLD.
- Meas accept, meas_data > 9999:
  - Saturate. Next cycle, digits = 9,9,9,9 and upd = 1.
  - Go to HOLD with no conversion.
- Meas accept, meas_data ≤ 9999:
  - Load the shift register with a zero BCD field and the binary value.
  - Go to CONV with the iteration count = 0.
- CONV, double-dabble, one iteration per clock, DATA_W iterations:
  - First, add 3 to each of the four BCD nibbles that is ≥ 5.
  - Then shift {bcd, bin} left by 1.
  - After the final iteration, digits load from the BCD field on the next edge, upd = 1, go to HOLD.
- Digits never change during CONV; the scan driver keeps showing the previous value.
- HOLD:
  - The counter counts 0..HOLD_CYC-1 and then returns to IDLE.
  - Both ready outputs stay 0 in HOLD and CONV.
  - Requests arriving then are not accepted and not latched; requesters hold valid or drop it, and the block has no queue.
- Leading zeros are displayed as 0; there is no blanking of leading digits.
- Reset, including mid-CONV or mid-HOLD:
  - State returns to IDLE.
  - All digits = 0, upd = 0, busy = 0.
  - Any in-flight conversion is discarded.
  - Both ready outputs are 0 while sys_rst = 1, and 1 on the first cycle after release if no err_valid.

## Timing
- Meas accept on edge N: digits valid and upd = 1 in cycle N + DATA_W + 1 (15 cycles at the default width).
- Saturated meas or error accept on edge N: digits and upd in cycle N+1.
- HOLD occupies exactly HOLD_CYC cycles after the upd cycle; ready reasserts in the following cycle.
- Minimum accept-to-accept spacing:
  - Conversion path: DATA_W + 1 + HOLD_CYC + 1 cycles.
  - Saturated or error path: HOLD_CYC + 2 cycles.
- All outputs are registered except meas_ready and err_ready.
- Counter widths:
  - Iteration counter: $clog2(DATA_W+1).
  - Hold counter: $clog2(HOLD_CYC+1).
  - Neither counter wraps; both clear on entering their state.

## Structure
- Package disp_pkg:
  - state enum {IDLE, CONV, HOLD}.
  - MAX_DISP = 9999.
  - BLANK = 4'hF.
  - BCD_DIGITS = 4.
- Sub-module bin2bcd_seq:
  - start/done iterative converter with DATA_W as a parameter.
  - Owns the shift register and iteration counter; done is a one-cycle pulse with a 16-bit BCD result.
- The scheduler owns arbitration, saturation, the hold timer and the digit registers.

## Test plan
All scenarios use HOLD_CYC = 8 and DATA_W = 14.
- Release reset with no requests → digits 0,0,0,0, busy = 0, meas_ready = 1, upd never pulses.
- meas_data = 1234 accepted → exactly 15 cycles later, digit3..0 = 1,2,3,4 with a single upd pulse; meas_ready is 0 for 15 + 8 cycles, then 1.
- meas_data = 12000 accepted → next cycle, digits = 9,9,9,9, no CONV state visited; values 9999 and 0 convert exactly.
- err_valid and meas_valid both high in IDLE → err accepted, meas_ready = 0; digits = F,F,F,F next cycle; after HOLD, the still-valid meas_data = 56 is accepted and displays 0,0,5,6.
- Request arriving mid-HOLD → ready stays 0; the request is accepted on the first IDLE cycle and not before.
- sys_rst asserted at iteration 7 of converting 4321 → digits 0,0,0,0 the next cycle, no upd pulse; a post-reset request for 77 displays 0,0,7,7.

Source files
------------

// File: rtl/disp_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_e;

    localparam int          MAX_DISP   = 9999;
    localparam logic [3:0]  BLANK      = 4'hF;
    localparam int          BCD_DIGITS = 4;

endpackage

// File: rtl/disp_scheduler_if.sv
// Request/response and digit bus between the requesters, the scheduler and the scan driver.
interface disp_scheduler_if #(
    parameter int DATA_W = 14
);
    logic              meas_valid;
    logic [DATA_W-1:0] meas_data;
    logic              meas_ready;
    logic              err_valid;
    logic              err_ready;
    logic [3:0]        digit0;
    logic [3:0]        digit1;
    logic [3:0]        digit2;
    logic [3:0]        digit3;
    logic              upd;
    logic              busy;

    modport slave (
        input  meas_valid, meas_data, err_valid,
        output meas_ready, err_ready, digit0, digit1, digit2, digit3, upd, busy
    );

    modport master (
        output meas_valid, meas_data, err_valid,
        input  meas_ready, err_ready, digit0, digit1, digit2, digit3, upd, busy
    );
endinterface

// File: rtl/disp_scheduler_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per clock, DATA_W steps.
// done_o is combinational on the last step so the caller can latch bcd_o on that edge.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DATA_W-1:0]         bin_i,
    output logic                      done_o,
    output logic [4*BCD_DIGITS-1:0]   bcd_o
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SR_W-1:0]  sr_q, sr_d, sr_adj, sr_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sr_q[DATA_W + 4*i +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*i +: 4] = sr_q[DATA_W + 4*i +: 4] + 4'd3;
        end
        sr_shift = sr_adj << 1;
    end

    assign done_o = act_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign bcd_o  = sr_shift[SR_W-1 -: BCD_W];

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        act_d = act_q;
        if (start_i) begin
            sr_d  = {{BCD_W{1'b0}}, bin_i};
            cnt_d = '0;
            act_d = 1'b1;
        end else if (act_q) begin
            sr_d = sr_shift;
            if (done_o) begin
                cnt_d = '0;
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/disp_scheduler.sv
// Arbitrates error/distance requests (error first), saturates or converts distances,
// drives the four BCD digits and holds each new value for HOLD_CYC clocks.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int DATA_W   = 14,
    parameter int HOLD_CYC = 25_000_000
) (
    input  logic            sys_clk50m,
    input  logic            sys_rst,
    disp_scheduler_if.slave bus
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_e                          state_q, state_d;
    logic [HOLD_W-1:0]               hold_q, hold_d;
    logic [BCD_DIGITS-1:0][3:0]      dig_q, dig_d;
    logic                            upd_q, upd_d;
    logic                            busy_q, busy_d;
    logic                            conv_start, conv_done, sat;
    logic [4*BCD_DIGITS-1:0]         conv_bcd;

    assign sat = 32'(bus.meas_data) > 32'(MAX_DISP);

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk_i   (sys_clk50m),
        .rst_i   (sys_rst),
        .start_i (conv_start),
        .bin_i   (bus.meas_data),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        dig_d          = dig_q;
        upd_d          = 1'b0;
        conv_start     = 1'b0;
        bus.meas_ready = 1'b0;
        bus.err_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.err_ready  = !sys_rst;
                bus.meas_ready = !sys_rst && !bus.err_valid;
                if (bus.err_valid && bus.err_ready) begin
                    dig_d   = {BCD_DIGITS{BLANK}};
                    upd_d   = 1'b1;
                    hold_d  = '0;
                    state_d = HOLD;
                end else if (bus.meas_valid && bus.meas_ready) begin
                    if (sat) begin
                        dig_d   = {BCD_DIGITS{4'd9}};
                        upd_d   = 1'b1;
                        hold_d  = '0;
                        state_d = HOLD;
                    end else begin
                        conv_start = 1'b1;
                        state_d    = CONV;
                    end
                end
            end
            CONV: begin
                if (conv_done) begin
                    dig_d   = conv_bcd;
                    upd_d   = 1'b1;
                    hold_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // The upd cycle itself is not part of the hold window.
                if (!upd_q) begin
                    if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                        hold_d  = '0;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dig_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dig_q   <= dig_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.digit0 = dig_q[0];
    assign bus.digit1 = dig_q[1];
    assign bus.digit2 = dig_q[2];
    assign bus.digit3 = dig_q[3];
    assign bus.upd    = upd_q;
    assign bus.busy   = busy_q;

endmodule
